// File: rtl/delaychain_probe.sv
// delaychain_probe: launch-and-capture latency measurement for an 8-lane delay chain.
// Drives one controlled edge into a selected lane, watches the same lane at the
// chain output and reports arrival latency in cycles, or a timeout.
// Optional build macro DELAYPROBE_SYNC_EN: inserts a 2-flop synchronizer on sense
// (adds 2 cycles to every reported latency).
module delaychain_probe #(
    parameter int unsigned CNT_W   = 12,
    parameter int unsigned TIMEOUT = 2047
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [2:0]       lane_sel_i,
    input  logic             edge_pol_i,
    output logic [7:0]       launch_o,
    input  logic [7:0]       sense_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic             stage_err_o,
    output logic [CNT_W-1:0] latency_o
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StSettle = 3'd1;
    localparam logic [2:0] StLaunch = 3'd2;
    localparam logic [2:0] StWait   = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

    logic [2:0]       state_q, state_d;
    logic [2:0]       lane_q, lane_d;
    logic             pol_q, pol_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       launch_q, launch_d;
    logic             timeout_q, timeout_d;
    logic             stage_err_q, stage_err_d;
    logic [CNT_W-1:0] latency_q, latency_d;
    logic [7:0]       sense_c;
    logic             lane_sense;

`ifdef DELAYPROBE_SYNC_EN
    logic [7:0] sync1_q, sync2_q;

    // Two-flop synchronizer per lane for chains built from unclocked delay cells.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sense_i;
            sync2_q <= sync1_q;
        end
    end

    assign sense_c = sync2_q;
`else
    assign sense_c = sense_i;
`endif

    assign lane_sense = sense_c[lane_q];

    // Measurement FSM: settle to the idle level, launch the edge, time its arrival.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        pol_d       = pol_q;
        cnt_d       = cnt_q;
        timeout_d   = timeout_q;
        stage_err_d = stage_err_q;
        latency_d   = latency_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StSettle;
                    lane_d      = lane_sel_i;
                    pol_d       = edge_pol_i;
                    cnt_d       = '0;
                    timeout_d   = 1'b0;
                    stage_err_d = 1'b0;
                    latency_d   = '0;
                end
            end
            StSettle: begin
                // Settling takes priority over a counter that just reached the limit.
                if (lane_sense == pol_q) begin
                    state_d = StLaunch;
                end else if (cnt_q == TimeoutVal) begin
                    timeout_d   = 1'b1;
                    stage_err_d = 1'b1;
                    latency_d   = TimeoutVal;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLaunch: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // Detection in the cycle the counter hits the limit is still a detection.
                if (lane_sense != pol_q) begin
                    latency_d = cnt_q;
                    state_d   = StDone;
                end else if (cnt_q == TimeoutVal) begin
                    timeout_d = 1'b1;
                    latency_d = TimeoutVal;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Launch drive follows the next state so the edge appears exactly at LAUNCH exit.
    always_comb begin
        launch_d = '0;
        case (state_d)
            StSettle, StLaunch: launch_d[lane_d] = pol_d;
            StWait:             launch_d[lane_d] = ~pol_d;
            default:            launch_d = '0;
        endcase
    end

    // State, configuration, counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            lane_q      <= '0;
            pol_q       <= 1'b0;
            cnt_q       <= '0;
            launch_q    <= '0;
            timeout_q   <= 1'b0;
            stage_err_q <= 1'b0;
            latency_q   <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            pol_q       <= pol_d;
            cnt_q       <= cnt_d;
            launch_q    <= launch_d;
            timeout_q   <= timeout_d;
            stage_err_q <= stage_err_d;
            latency_q   <= latency_d;
        end
    end

    assign launch_o    = launch_q;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign timeout_o   = timeout_q;
    assign stage_err_o = stage_err_q;
    assign latency_o   = latency_q;

endmodule

// File: tb/tb_delaychain_probe.sv
// Directed bench for delaychain_probe: models chain lanes as shift registers,
// stuck lines and a direct wire, and checks results with immediate assertions.
module tb_delaychain_probe;

`ifdef DELAYPROBE_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        start_t;
    logic [2:0]  lane_sel;
    logic        edge_pol;
    logic [7:0]  sense;
    logic [7:0]  launch, launch_t;
    logic        busy, done, tmo, serr;
    logic        busy_t, done_t, tmo_t, serr_t;
    logic [11:0] lat, lat_t;

    logic [499:0] ch0;
    logic [9:0]   ch3;

    int checks = 0;
    int errors = 0;

    delaychain_probe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .lane_sel_i  (lane_sel),
        .edge_pol_i  (edge_pol),
        .launch_o    (launch),
        .sense_i     (sense),
        .busy_o      (busy),
        .done_o      (done),
        .timeout_o   (tmo),
        .stage_err_o (serr),
        .latency_o   (lat)
    );

    delaychain_probe #(.CNT_W(12), .TIMEOUT(100)) dut_t (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_t),
        .lane_sel_i  (lane_sel),
        .edge_pol_i  (edge_pol),
        .launch_o    (launch_t),
        .sense_i     (sense),
        .busy_o      (busy_t),
        .done_o      (done_t),
        .timeout_o   (tmo_t),
        .stage_err_o (serr_t),
        .latency_o   (lat_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chain models: lane 0 = 500 stages, lane 3 = 10 stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch0 <= '0;
            ch3 <= '0;
        end else begin
            ch0 <= {ch0[498:0], launch[0]};
            ch3 <= {ch3[8:0], launch[3]};
        end
    end

    // Lane 1 direct wire, lane 5 stuck at 1, lane 7 and the rest stuck at 0.
    assign sense = {1'b0, 1'b0, 1'b1, 1'b0, ch3[9], 1'b0, launch[1], ch0[499]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Tick until done (main or timeout instance) or budget expires; n = ticks taken.
    task automatic wait_done(input bit use_t, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(use_t ? done_t : done) && n < budget);
    endtask

    initial begin
        int n;
        int pulses;
        rst_n    = 1'b0;
        start    = 1'b0;
        start_t  = 1'b0;
        lane_sel = 3'd0;
        edge_pol = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_launch", 32'(launch), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(tmo), 32'd0);
        check("rst_stage_err", 32'(serr), 32'd0);
        check("rst_latency", 32'(lat), 32'd0);

        // Lane 3, 10 stages, rising edge
        lane_sel = 3'd3;
        edge_pol = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("l3_busy_rise", 32'(busy), 32'd1);
        check("l3_launch_idle", 32'(launch), 32'd0);
        wait_done(1'b0, 200, n);
        check("l3_done", 32'(done), 32'd1);
        check("l3_cycles", 32'(n), 32'(10 + S + 3));
        check("l3_latency", 32'(lat), 32'(10 + S));
        check("l3_timeout", 32'(tmo), 32'd0);
        check("l3_stage_err", 32'(serr), 32'd0);
        check("l3_busy_in_done", 32'(busy), 32'd1);
        tick();
        check("l3_busy_fall", 32'(busy), 32'd0);
        check("l3_done_pulse", 32'(done), 32'd0);
        check("l3_launch_end", 32'(launch), 32'd0);

        // Lane 1 direct wire: minimum time, start held for back-to-back
        lane_sel = 3'd1;
        edge_pol = 1'b0;
        start    = 1'b1;
        tick();
        wait_done(1'b0, 50, n);
        check("min_done", 32'(done), 32'd1);
        check("min_cycles", 32'(n), 32'(S + 3));
        check("min_latency", 32'(lat), 32'(S));
        tick();
        check("b2b_idle_busy", 32'(busy), 32'd0);
        tick();
        check("b2b_restart_busy", 32'(busy), 32'd1);
        check("b2b_cleared_lat", 32'(lat), 32'd0);
        start = 1'b0;
        wait_done(1'b0, 50, n);
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_cycles", 32'(n), 32'(S + 3));
        check("b2b_latency", 32'(lat), 32'(S));
        tick();

        // Lane 0, 500 stages, falling edge
        lane_sel = 3'd0;
        edge_pol = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("l0_launch_idle", 32'(launch), 32'd1);
        wait_done(1'b0, 2000, n);
        check("l0_done", 32'(done), 32'd1);
        check("l0_latency", 32'(lat), 32'(500 + S));
        check("l0_timeout", 32'(tmo), 32'd0);
        tick();
        check("l0_launch_end", 32'(launch), 32'd0);

        // Lane 7 stuck at 0 on the TIMEOUT=100 instance: WAIT timeout
        lane_sel = 3'd7;
        edge_pol = 1'b0;
        start_t  = 1'b1;
        tick();
        start_t = 1'b0;
        wait_done(1'b1, 300, n);
        check("to_done", 32'(done_t), 32'd1);
        check("to_cycles", 32'(n), 32'd103);
        check("to_timeout", 32'(tmo_t), 32'd1);
        check("to_stage_err", 32'(serr_t), 32'd0);
        check("to_latency", 32'(lat_t), 32'd100);
        tick();
        check("to_launch_end", 32'(launch_t), 32'd0);

        // Lane 5 stuck at 1, rising: SETTLE timeout; stray start while busy
        lane_sel = 3'd5;
        edge_pol = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        lane_sel = 3'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b0, 2200, n);
        check("se_done", 32'(done), 32'd1);
        check("se_cycles", 32'(n + 11), 32'd2048);
        check("se_timeout", 32'(tmo), 32'd1);
        check("se_stage_err", 32'(serr), 32'd1);
        check("se_latency", 32'(lat), 32'd2047);
        pulses = 0;
        repeat (30) begin
            tick();
            if (done) pulses++;
        end
        check("se_no_second_done", 32'(pulses), 32'd0);
        check("se_idle_busy", 32'(busy), 32'd0);

        // Reset during WAIT on lane 7 (stuck at 0, long TIMEOUT)
        lane_sel = 3'd7;
        edge_pol = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        check("rw_launch_wait", 32'(launch), 32'h80);
        #1;
        rst_n = 1'b0;
        #1;
        check("rw_launch_rst", 32'(launch), 32'd0);
        check("rw_busy_rst", 32'(busy), 32'd0);
        check("rw_timeout_rst", 32'(tmo), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        pulses = 0;
        repeat (30) begin
            tick();
            if (done || busy) pulses++;
        end
        check("rw_no_done", 32'(pulses), 32'd0);
        check("rw_latency", 32'(lat), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d",
                 errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
